// File: rtl/soc_mem_arbiter.sv
// Two-port arbiter sharing one single-port, byte-writable SRAM (1-cycle read latency)
// between the Ibex instruction-fetch port (port 0) and data port (port 1).
module soc_mem_arbiter #(
   parameter int unsigned WORDS      = 128,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   output logic        p0_gnt,
   input  logic        p0_we,
   input  logic [3:0]  p0_be,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_rvalid,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   output logic        p1_gnt,
   input  logic        p1_we,
   input  logic [3:0]  p1_be,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_rvalid,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic        mem_ena,
   output logic [3:0]  mem_wen,
   output logic [21:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // 33-bit window end so a window touching the top of the address space cannot wrap.
   localparam logic [32:0] WINDOW_END = {1'b0, BASE_ADDR} + 33'(WORDS) * 33'd4;

   logic        last_gnt_q,   last_gnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_port_q,  resp_port_d;
   logic        resp_we_q,    resp_we_d;
   logic        resp_err_q,   resp_err_d;

   logic        sel_p1;
   logic        gnt_p0;
   logic        gnt_p1;
   logic        gnt_any;
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        in_range;
   logic        resp_live;
   logic [31:0] resp_rdata;

   // last_gnt holds the port granted most recently; on contention the other one wins.
   always_comb begin
      sel_p1 = 1'b0;
      gnt_p0 = 1'b0;
      gnt_p1 = 1'b0;
      if (p0_req && p1_req) begin
         sel_p1 = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
      end else begin
         sel_p1 = p1_req;
      end
      if (!reset) begin
         gnt_p0 = p0_req && !sel_p1;
         gnt_p1 = p1_req && sel_p1;
      end
   end

   assign gnt_any = gnt_p0 || gnt_p1;
   assign p0_gnt  = gnt_p0;
   assign p1_gnt  = gnt_p1;

   assign sel_we    = sel_p1 ? p1_we    : p0_we;
   assign sel_be    = sel_p1 ? p1_be    : p0_be;
   assign sel_addr  = sel_p1 ? p1_addr  : p0_addr;
   assign sel_wdata = sel_p1 ? p1_wdata : p0_wdata;

   assign in_range = ({1'b0, sel_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, sel_addr} < WINDOW_END);

   always_comb begin
      mem_ena   = 1'b0;
      mem_wen   = 4'b0000;
      mem_addr  = 22'((sel_addr - BASE_ADDR) >> 2);
      mem_wdata = sel_wdata;
      if (gnt_any && in_range) begin
         mem_ena = 1'b1;
         mem_wen = sel_we ? sel_be : 4'b0000;
      end
   end

   always_comb begin
      last_gnt_d   = last_gnt_q;
      resp_valid_d = gnt_any;
      resp_port_d  = resp_port_q;
      resp_we_d    = resp_we_q;
      resp_err_d   = resp_err_q;
      if (gnt_any) begin
         last_gnt_d  = gnt_p1;
         resp_port_d = gnt_p1;
         resp_we_d   = sel_we;
         resp_err_d  = !in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q   <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_port_q  <= 1'b0;
         resp_we_q    <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         resp_valid_q <= resp_valid_d;
         resp_port_q  <= resp_port_d;
         resp_we_q    <= resp_we_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // A response still in flight when reset rises is suppressed, not delivered late.
   assign resp_live  = resp_valid_q && !reset;
   assign resp_rdata = (resp_err_q || resp_we_q) ? 32'h0 : mem_rdata;

   assign p0_rvalid = resp_live && !resp_port_q;
   assign p1_rvalid = resp_live && resp_port_q;
   assign p0_err    = p0_rvalid && resp_err_q;
   assign p1_err    = p1_rvalid && resp_err_q;
   assign p0_rdata  = p0_rvalid ? resp_rdata : 32'h0;
   assign p1_rdata  = p1_rvalid ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: three instances (round-robin, fixed priority, offset window)
// sharing one stimulus stream, each with its own SRAM and a transaction-level reference model.
module tb_soc_mem_arbiter;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } port_req_t;

   logic        clk;
   logic        reset;
   logic        init_ram;
   logic        p0_req, p1_req;
   logic        p0_we, p1_we;
   logic [3:0]  p0_be, p1_be;
   logic [31:0] p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;

   logic        p0_gnt    [3];
   logic        p1_gnt    [3];
   logic        p0_rvalid [3];
   logic        p1_rvalid [3];
   logic        p0_err    [3];
   logic        p1_err    [3];
   logic [31:0] p0_rdata  [3];
   logic [31:0] p1_rdata  [3];
   logic        mem_ena   [3];
   logic [3:0]  mem_wen   [3];
   logic [21:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];

   int total;
   int bad;

   // Reference state: memory image, last winner, and the response owed next cycle.
   logic [31:0] model_mem [3][128];
   int          last_win  [3];
   bit          pend_v    [3];
   int          pend_port [3];
   bit          pend_err  [3];
   logic [31:0] pend_data [3];

   function automatic logic [31:0] initWord(int i);
      return (i == 4) ? 32'h1122_3344 : (32'hA500_0000 ^ (32'(i) * 32'h0001_0101));
   endfunction

   function automatic logic [31:0] baseOf(int k);
      return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [31:0] ram [0:127];
      logic [31:0] rd;

      soc_mem_arbiter #(
         .WORDS      (128),
         .BASE_ADDR  (g == 2 ? 32'h0000_1000 : 32'h0000_0000),
         .FIXED_PRIO (g == 1)
      ) dut (
         .clk       (clk),
         .reset     (reset),
         .p0_req    (p0_req),
         .p0_gnt    (p0_gnt[g]),
         .p0_we     (p0_we),
         .p0_be     (p0_be),
         .p0_addr   (p0_addr),
         .p0_wdata  (p0_wdata),
         .p0_rvalid (p0_rvalid[g]),
         .p0_err    (p0_err[g]),
         .p0_rdata  (p0_rdata[g]),
         .p1_req    (p1_req),
         .p1_gnt    (p1_gnt[g]),
         .p1_we     (p1_we),
         .p1_be     (p1_be),
         .p1_addr   (p1_addr),
         .p1_wdata  (p1_wdata),
         .p1_rvalid (p1_rvalid[g]),
         .p1_err    (p1_err[g]),
         .p1_rdata  (p1_rdata[g]),
         .mem_ena   (mem_ena[g]),
         .mem_wen   (mem_wen[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (rd)
      );

      // Single-port SRAM: byte writes at the edge, registered read of the old word.
      always @(posedge clk) begin
         if (init_ram) begin
            for (int i = 0; i < 128; i++) ram[i] <= initWord(i);
         end else if (mem_ena[g]) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_wen[g][b]) ram[mem_addr[g][6:0]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
            end
            rd <= ram[mem_addr[g][6:0]];
         end
      end
   end

   task automatic checkOutput(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Arbitration and response expectations derived from the transaction rules.
   task automatic modelCheck(input logic r, input port_req_t a, input port_req_t b);
      int          w;
      port_req_t   t;
      logic [31:0] base;
      logic [31:0] off;
      longint      a64;
      longint      b64;
      bit          inr;
      logic [3:0]  exp_wen;
      for (int k = 0; k < 3; k++) begin
         base = baseOf(k);
         checkOutput("p0_rvalid", k, 32'(p0_rvalid[k]), 32'(!r && pend_v[k] && pend_port[k] == 0));
         checkOutput("p1_rvalid", k, 32'(p1_rvalid[k]), 32'(!r && pend_v[k] && pend_port[k] == 1));
         checkOutput("p0_err", k, 32'(p0_err[k]), 32'(!r && pend_v[k] && pend_port[k] == 0 && pend_err[k]));
         checkOutput("p1_err", k, 32'(p1_err[k]), 32'(!r && pend_v[k] && pend_port[k] == 1 && pend_err[k]));
         checkOutput("p0_rdata", k, p0_rdata[k], (!r && pend_v[k] && pend_port[k] == 0) ? pend_data[k] : 32'h0);
         checkOutput("p1_rdata", k, p1_rdata[k], (!r && pend_v[k] && pend_port[k] == 1) ? pend_data[k] : 32'h0);
         if (r) begin
            checkOutput("rst_gnt0", k, 32'(p0_gnt[k]), 32'h0);
            checkOutput("rst_gnt1", k, 32'(p1_gnt[k]), 32'h0);
            checkOutput("rst_ena", k, 32'(mem_ena[k]), 32'h0);
            checkOutput("rst_wen", k, 32'(mem_wen[k]), 32'h0);
            pend_v[k]   = 1'b0;
            last_win[k] = 1;
            continue;
         end
         w = -1;
         if (a.req && b.req) w = (k == 1) ? 0 : ((last_win[k] == 0) ? 1 : 0);
         else if (a.req) w = 0;
         else if (b.req) w = 1;
         checkOutput("gnt0", k, 32'(p0_gnt[k]), 32'(w == 0));
         checkOutput("gnt1", k, 32'(p1_gnt[k]), 32'(w == 1));
         t   = (w == 1) ? b : a;
         a64 = longint'(t.addr);
         b64 = longint'(base);
         inr = (a64 >= b64) && (a64 < b64 + 512);
         off = t.addr - base;
         exp_wen = (w >= 0 && inr && t.we) ? t.be : 4'b0000;
         checkOutput("mem_ena", k, 32'(mem_ena[k]), 32'(w >= 0 && inr));
         checkOutput("mem_wen", k, 32'(mem_wen[k]), 32'(exp_wen));
         if (w >= 0 && inr) checkOutput("mem_addr", k, 32'(mem_addr[k]), 32'(off[23:2]));
         if (exp_wen != 4'b0000) checkOutput("mem_wdata", k, mem_wdata[k], t.wdata);
         pend_v[k] = (w >= 0);
         if (w >= 0) begin
            pend_port[k] = w;
            pend_err[k]  = !inr;
            pend_data[k] = (!inr || t.we) ? 32'h0 : model_mem[k][off[8:2]];
            if (inr && t.we) begin
               for (int bb = 0; bb < 4; bb++) begin
                  if (t.be[bb]) model_mem[k][off[8:2]][bb*8 +: 8] = t.wdata[bb*8 +: 8];
               end
            end
            last_win[k] = w;
         end
      end
   endtask

   // Drives one cycle of inputs at the falling edge, then checks every instance.
   task automatic applyStimulus(input logic r, input port_req_t a, input port_req_t b);
      @(negedge clk);
      reset    = r;
      p0_req   = a.req;
      p0_we    = a.we;
      p0_be    = a.be;
      p0_addr  = a.addr;
      p0_wdata = a.wdata;
      p1_req   = b.req;
      p1_we    = b.we;
      p1_be    = b.be;
      p1_addr  = b.addr;
      p1_wdata = b.wdata;
      #1;
      modelCheck(r, a, b);
   endtask

   function automatic port_req_t makeRead(logic [31:0] addr);
      port_req_t t;
      t.req = 1'b1; t.we = 1'b0; t.be = 4'hF; t.addr = addr; t.wdata = 32'h0;
      return t;
   endfunction

   function automatic port_req_t makeWrite(logic [31:0] addr, logic [3:0] be, logic [31:0] data);
      port_req_t t;
      t.req = 1'b1; t.we = 1'b1; t.be = be; t.addr = addr; t.wdata = data;
      return t;
   endfunction

   function automatic port_req_t noReq();
      port_req_t t;
      t.req = 1'b0; t.we = 1'($urandom_range(0, 1)); t.be = 4'($urandom);
      t.addr = $urandom; t.wdata = $urandom;
      return t;
   endfunction

   function automatic port_req_t randomReq();
      port_req_t   t;
      logic [31:0] word;
      t.req   = ($urandom_range(0, 3) != 0);
      t.we    = 1'($urandom_range(0, 1));
      t.be    = 4'($urandom);
      t.wdata = $urandom;
      word    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 127)) : 32'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
         0, 1, 2: t.addr = (word << 2) | 32'($urandom_range(0, 3));
         3:       t.addr = 32'h0000_0FF0 + (word << 2);
         4:       t.addr = 32'h0000_01F0 + (word << 2);
         default: t.addr = $urandom;
      endcase
      return t;
   endfunction

   initial begin
      port_req_t ra;
      port_req_t rb;
      logic      rr;
      total    = 0;
      bad      = 0;
      init_ram = 1'b1;
      reset    = 1'b1;
      p0_req   = 1'b0;
      p1_req   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 128; i++) model_mem[k][i] = initWord(i);
         last_win[k] = 1;
         pend_v[k]   = 1'b0;
         pend_port[k] = 0;
         pend_err[k]  = 1'b0;
         pend_data[k] = 32'h0;
      end

      $display("[TB] reset held with both ports requesting");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, makeRead(32'h0), makeRead(32'h4));
         checkOutput("reset_gnt0", 0, 32'(p0_gnt[0]), 32'h0);
         checkOutput("reset_ena", 0, 32'(mem_ena[0]), 32'h0);
         checkOutput("reset_rvalid", 0, 32'(p0_rvalid[0] | p1_rvalid[0]), 32'h0);
      end
      init_ram = 1'b0;
      applyStimulus(1'b0, makeRead(32'h0), makeRead(32'h4));
      checkOutput("first_gnt_p0", 0, 32'(p0_gnt[0]), 32'h1);
      checkOutput("first_gnt_p1", 0, 32'(p1_gnt[0]), 32'h0);

      $display("[TB] port 1 partial write then read-back");
      applyStimulus(1'b0, noReq(), makeWrite(32'h10, 4'b0011, 32'hAABB_CCDD));
      applyStimulus(1'b0, noReq(), makeRead(32'h10));
      checkOutput("wr_rvalid", 0, 32'(p1_rvalid[0]), 32'h1);
      checkOutput("wr_rdata", 0, p1_rdata[0], 32'h0);
      applyStimulus(1'b0, noReq(), noReq());
      checkOutput("rd_rvalid", 0, 32'(p1_rvalid[0]), 32'h1);
      checkOutput("rd_rdata", 0, p1_rdata[0], 32'h1122_CCDD);

      $display("[TB] contention");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, makeRead(32'(i * 4)), makeRead(32'h40 + 32'(i * 4)));
         checkOutput("rr_gnt_p0", 0, 32'(p0_gnt[0]), 32'(i % 2 == 0));
         checkOutput("rr_gnt_p1", 0, 32'(p1_gnt[0]), 32'(i % 2 == 1));
         if (i < 4) begin
            checkOutput("fp_gnt_p0", 1, 32'(p0_gnt[1]), 32'h1);
            checkOutput("fp_gnt_p1", 1, 32'(p1_gnt[1]), 32'h0);
         end
      end
      applyStimulus(1'b0, noReq(), makeRead(32'h44));
      checkOutput("fp_handoff", 1, 32'(p1_gnt[1]), 32'h1);
      applyStimulus(1'b0, noReq(), noReq());

      $display("[TB] out-of-range accesses");
      applyStimulus(1'b0, makeRead(32'h200), noReq());
      checkOutput("oor_gnt", 0, 32'(p0_gnt[0]), 32'h1);
      checkOutput("oor_ena", 0, 32'(mem_ena[0]), 32'h0);
      applyStimulus(1'b0, makeRead(32'hFFC), noReq());
      checkOutput("oor_rvalid", 0, 32'(p0_rvalid[0]), 32'h1);
      checkOutput("oor_err", 0, 32'(p0_err[0]), 32'h1);
      checkOutput("oor_rdata", 0, p0_rdata[0], 32'h0);
      checkOutput("below_gnt", 2, 32'(p0_gnt[2]), 32'h1);
      checkOutput("below_ena", 2, 32'(mem_ena[2]), 32'h0);
      applyStimulus(1'b0, noReq(), noReq());
      checkOutput("below_rvalid", 2, 32'(p0_rvalid[2]), 32'h1);
      checkOutput("below_err", 2, 32'(p0_err[2]), 32'h1);
      checkOutput("below_rdata", 2, p0_rdata[2], 32'h0);

      $display("[TB] back-to-back write/read across ports");
      applyStimulus(1'b0, makeWrite(32'h0, 4'hF, 32'hDEAD_BEEF), noReq());
      applyStimulus(1'b0, noReq(), makeRead(32'h0));
      applyStimulus(1'b0, noReq(), noReq());
      checkOutput("raw_rvalid", 0, 32'(p1_rvalid[0]), 32'h1);
      checkOutput("raw_rdata", 0, p1_rdata[0], 32'hDEAD_BEEF);

      $display("[TB] reset right after a grant");
      applyStimulus(1'b0, makeRead(32'h8), noReq());
      checkOutput("pre_rst_gnt", 0, 32'(p0_gnt[0]), 32'h1);
      applyStimulus(1'b1, noReq(), makeRead(32'hC));
      checkOutput("drop_rvalid_a", 0, 32'(p0_rvalid[0]), 32'h0);
      applyStimulus(1'b1, noReq(), makeRead(32'hC));
      checkOutput("drop_rvalid_b", 0, 32'(p0_rvalid[0]), 32'h0);
      applyStimulus(1'b0, makeRead(32'h8), makeRead(32'hC));
      checkOutput("drop_rvalid_c", 0, 32'(p0_rvalid[0]), 32'h0);
      checkOutput("post_rst_gnt", 0, 32'(p0_gnt[0]), 32'h1);
      applyStimulus(1'b0, noReq(), noReq());

      $display("[TB] randomized traffic");
      for (int n = 0; n < 3000; n++) begin
         rr = ($urandom_range(0, 63) == 0);
         ra = randomReq();
         rb = randomReq();
         applyStimulus(rr, ra, rb);
      end
      applyStimulus(1'b0, noReq(), noReq());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
